// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited in-order fetch requests, response FIFO toward decode.
// A redirect flushes the FIFO and marks every in-flight response for discard.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        IMEM_REQ_VALID,
    input  logic        IMEM_REQ_READY,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_RESP_VALID,
    input  logic [31:0] IMEM_RESP_DATA,
    input  logic        REDIRECT_VALID,
    input  logic [31:0] REDIRECT_PC,
    output logic        INSTR_VALID,
    input  logic        INSTR_READY,
    output logic [31:0] INSTRUCTION,
    output logic [31:0] INSTR_PC
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [31:0]   r_pc;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW-1:0] r_iw;
    logic [AW-1:0] r_ir;

    logic [31:0] r_data [DEPTH];
    logic [31:0] r_fpc  [DEPTH];
    logic [31:0] r_ipc  [DEPTH];

    logic          w_acc;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_live;
    logic [CW-1:0] w_credit;
    logic [CW-1:0] w_out_nxt;
    logic          w_unused_redir;

    // Credits cover both buffered words and live in-flight fetches, so a response always fits.
    assign w_live         = r_outstanding - r_drop;
    assign w_credit       = r_count + w_live;
    assign IMEM_REQ_VALID = !RST && !REDIRECT_VALID && (w_credit < CW'(DEPTH));
    assign IMEM_ADDR      = r_pc;

    assign w_acc     = IMEM_REQ_VALID && IMEM_REQ_READY;
    assign w_push    = IMEM_RESP_VALID && (r_drop == '0) && !REDIRECT_VALID;
    assign w_pop     = INSTR_VALID && INSTR_READY && !REDIRECT_VALID;
    assign w_out_nxt = r_outstanding + CW'(w_acc) - CW'(IMEM_RESP_VALID);

    assign INSTR_VALID    = (r_count != '0);
    assign INSTRUCTION    = INSTR_VALID ? r_data[r_rptr] : '0;
    assign INSTR_PC       = INSTR_VALID ? r_fpc[r_rptr] : '0;
    assign w_unused_redir = ^REDIRECT_PC[1:0];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pc          <= RESET_PC;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop        <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_iw          <= '0;
            r_ir          <= '0;
        end else begin
            r_outstanding <= w_out_nxt;
            if (w_acc) begin
                r_iw <= r_iw + AW'(1);
            end
            if (IMEM_RESP_VALID) begin
                r_ir <= r_ir + AW'(1);
            end
            if (REDIRECT_VALID) begin
                // Everything still in flight after this cycle belongs to the old path.
                r_pc    <= {REDIRECT_PC[31:2], 2'b00};
                r_count <= '0;
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_drop  <= w_out_nxt;
            end else begin
                if (w_acc) begin
                    r_pc <= r_pc + 32'd4;
                end
                if (w_push) begin
                    r_wptr <= r_wptr + AW'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + AW'(1);
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
                if (IMEM_RESP_VALID && (r_drop != '0)) begin
                    r_drop <= r_drop - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_acc) begin
            r_ipc[r_iw] <= r_pc;
        end
        if (w_push) begin
            r_data[r_wptr] <= IMEM_RESP_DATA;
            r_fpc[r_wptr]  <= r_ipc[r_ir];
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order, fixed-latency instruction memory model.
module tb_fetch_unit;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] XMASK = 32'hA5A5_0000;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        IMEM_REQ_VALID;
    logic        IMEM_REQ_READY = 1'b0;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_RESP_VALID = 1'b0;
    logic [31:0] IMEM_RESP_DATA = '0;
    logic        REDIRECT_VALID = 1'b0;
    logic [31:0] REDIRECT_PC = '0;
    logic        INSTR_VALID;
    logic        INSTR_READY = 1'b0;
    logic [31:0] INSTRUCTION;
    logic [31:0] INSTR_PC;

    always #5 CLK = ~CLK;

    fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .DEPTH   (DEPTH)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .IMEM_REQ_VALID (IMEM_REQ_VALID),
        .IMEM_REQ_READY (IMEM_REQ_READY),
        .IMEM_ADDR      (IMEM_ADDR),
        .IMEM_RESP_VALID(IMEM_RESP_VALID),
        .IMEM_RESP_DATA (IMEM_RESP_DATA),
        .REDIRECT_VALID (REDIRECT_VALID),
        .REDIRECT_PC    (REDIRECT_PC),
        .INSTR_VALID    (INSTR_VALID),
        .INSTR_READY    (INSTR_READY),
        .INSTRUCTION    (INSTRUCTION),
        .INSTR_PC       (INSTR_PC)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          lat      = 1;
    int          n_acc    = 0;
    req_t        mq[$];
    logic [31:0] acc_addr[$];
    logic [31:0] cons_pc[$];
    logic [31:0] cons_data[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] qat(input logic [31:0] q[$], input int k);
        return (q.size() > k) ? q[k] : 32'hDEAD_BEEF;
    endfunction

    always @(posedge CLK) cyc++;

    // Handshakes are sampled just before the edge that completes them.
    always begin
        @(negedge CLK);
        #4;
        if (!RST && IMEM_REQ_VALID && IMEM_REQ_READY) begin
            mq.push_back('{IMEM_ADDR, cyc + lat});
            acc_addr.push_back(IMEM_ADDR);
            n_acc++;
        end
        if (!RST && INSTR_VALID && INSTR_READY && !REDIRECT_VALID) begin
            cons_pc.push_back(INSTR_PC);
            cons_data.push_back(INSTRUCTION);
        end
    end

    always @(negedge CLK) begin
        if (!RST && mq.size() > 0 && mq[0].due <= cyc) begin
            IMEM_RESP_VALID = 1'b1;
            IMEM_RESP_DATA  = mq[0].addr ^ XMASK;
            void'(mq.pop_front());
        end else begin
            IMEM_RESP_VALID = 1'b0;
            IMEM_RESP_DATA  = '0;
        end
    end

    always @(negedge CLK) begin
        if (!RST) begin
            check_eq("inv_outstanding", 32'(dut.r_outstanding <= DEPTH), 32'd1);
            check_eq("inv_drop", 32'(dut.r_drop <= dut.r_outstanding), 32'd1);
            check_eq("inv_fifo", 32'(dut.r_count <= DEPTH), 32'd1);
        end
    end

    task automatic assert_rst();
        @(negedge CLK);
        #2;
        RST             = 1'b1;
        REDIRECT_VALID  = 1'b0;
        IMEM_RESP_VALID = 1'b0;
        mq.delete();
        acc_addr.delete();
        cons_pc.delete();
        cons_data.delete();
        n_acc = 0;
    endtask

    task automatic release_rst();
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Streaming with single-cycle memory latency.
        lat = 1; IMEM_REQ_READY = 1'b1; INSTR_READY = 1'b1;
        assert_rst();
        #1;
        check_eq("rst_req_valid", 32'(IMEM_REQ_VALID), 32'd0);
        check_eq("rst_instr_valid", 32'(INSTR_VALID), 32'd0);
        check_eq("rst_instruction", INSTRUCTION, 32'd0);
        check_eq("rst_instr_pc", INSTR_PC, 32'd0);
        release_rst();
        #1;
        check_eq("t1_req_valid_c0", 32'(IMEM_REQ_VALID), 32'd1);
        check_eq("t1_addr_c0", IMEM_ADDR, 32'd0);
        check_eq("t1_ivalid_c0", 32'(INSTR_VALID), 32'd0);
        @(negedge CLK); #1;
        check_eq("t1_ivalid_c1", 32'(INSTR_VALID), 32'd0);
        for (int k = 2; k < 10; k++) begin
            @(negedge CLK); #1;
            check_eq("t1_ivalid", 32'(INSTR_VALID), 32'd1);
            check_eq("t1_pc", INSTR_PC, 32'(4 * (k - 2)));
            check_eq("t1_data", INSTRUCTION, 32'(4 * (k - 2)) ^ XMASK);
        end

        // Decoder stalled: credits cap requests at DEPTH.
        INSTR_READY = 1'b0;
        assert_rst();
        release_rst();
        repeat (20) @(negedge CLK);
        #1;
        check_eq("t2_n_acc", 32'(n_acc), 32'd4);
        check_eq("t2_last_addr", qat(acc_addr, 3), 32'd12);
        check_eq("t2_req_valid", 32'(IMEM_REQ_VALID), 32'd0);
        INSTR_READY = 1'b1;
        repeat (8) @(negedge CLK);
        #1;
        for (int k = 0; k < 5; k++) begin
            check_eq("t2_pc", qat(cons_pc, k), 32'(4 * k));
        end
        check_eq("t2_data4", qat(cons_data, 4), 32'd16 ^ XMASK);

        // Memory not ready: request held stable, counted once.
        IMEM_REQ_READY = 1'b0;
        assert_rst();
        release_rst();
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq("t3_addr_hold", IMEM_ADDR, 32'd0);
            check_eq("t3_valid_hold", 32'(IMEM_REQ_VALID), 32'd1);
            @(negedge CLK);
        end
        IMEM_REQ_READY = 1'b1;
        @(negedge CLK);
        IMEM_REQ_READY = 1'b0;
        #1;
        check_eq("t3_n_acc", 32'(n_acc), 32'd1);
        check_eq("t3_next_addr", IMEM_ADDR, 32'd4);

        // Redirect with two stale fetches in flight.
        lat = 3; IMEM_REQ_READY = 1'b1; INSTR_READY = 1'b1;
        assert_rst();
        release_rst();
        repeat (2) @(negedge CLK);
        IMEM_REQ_READY = 1'b0;
        REDIRECT_VALID = 1'b1;
        REDIRECT_PC    = 32'h0000_0103;
        #1;
        check_eq("t4_req_forced_low", 32'(IMEM_REQ_VALID), 32'd0);
        check_eq("t4_n_acc", 32'(n_acc), 32'd2);
        @(negedge CLK);
        REDIRECT_VALID = 1'b0;
        IMEM_REQ_READY = 1'b1;
        #1;
        check_eq("t4_new_addr", IMEM_ADDR, 32'h0000_0100);
        check_eq("t4_ivalid_t1", 32'(INSTR_VALID), 32'd0);
        repeat (10) @(negedge CLK);
        #1;
        check_eq("t4_pc0", qat(cons_pc, 0), 32'h0000_0100);
        check_eq("t4_data0", qat(cons_data, 0), 32'h0000_0100 ^ XMASK);
        check_eq("t4_pc1", qat(cons_pc, 1), 32'h0000_0104);

        // Redirect coinciding with a response and a decoder pop.
        lat = 1;
        assert_rst();
        release_rst();
        repeat (4) @(negedge CLK);
        REDIRECT_VALID = 1'b1;
        REDIRECT_PC    = 32'h0000_0200;
        #1;
        check_eq("t5_pc_at_redirect", INSTR_PC, 32'd8);
        @(negedge CLK);
        REDIRECT_VALID = 1'b0;
        #1;
        check_eq("t5_ivalid_t1", 32'(INSTR_VALID), 32'd0);
        check_eq("t5_new_addr", IMEM_ADDR, 32'h0000_0200);
        check_eq("t5_consumed", 32'(cons_pc.size()), 32'd2);
        repeat (5) @(negedge CLK);
        #1;
        check_eq("t5_pc2", qat(cons_pc, 2), 32'h0000_0200);
        check_eq("t5_pc3", qat(cons_pc, 3), 32'h0000_0204);

        // Asynchronous reset with fetches outstanding.
        lat = 3;
        assert_rst();
        release_rst();
        repeat (3) @(negedge CLK);
        #1;
        check_eq("t6_ivalid_pre", 32'(INSTR_VALID), 32'd0);
        #1;
        RST = 1'b1;
        mq.delete();
        #1;
        check_eq("t6_req_valid_rst", 32'(IMEM_REQ_VALID), 32'd0);
        check_eq("t6_ivalid_rst", 32'(INSTR_VALID), 32'd0);
        check_eq("t6_instruction_rst", INSTRUCTION, 32'd0);
        check_eq("t6_pc_rst", INSTR_PC, 32'd0);
        assert_rst();
        release_rst();
        #1;
        check_eq("t6_restart_addr", IMEM_ADDR, 32'd0);
        check_eq("t6_restart_valid", 32'(IMEM_REQ_VALID), 32'd1);
        repeat (10) @(negedge CLK);
        #1;
        check_eq("t6_pc0", qat(cons_pc, 0), 32'd0);
        check_eq("t6_pc1", qat(cons_pc, 1), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
